uart_tx_scheduler: RTL and testbench

// - Shares one byte-wide UART transmitter between NUM_REQ requesters (debug console, status reporter, etc.).
// - Round-robin arbitration per byte; optional packet lock keeps the grant until the requester's last byte.
// - Launches each byte with a one-cycle start strobe and tracks the transmitter's busy flag.
// - Flags a transmitter that never acknowledges a start.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduler and its helpers.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RISE,
        WAIT_FALL,
        RELEASE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every output gets a default before the loop so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign grant_any = |req_valid;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NUM_REQ
// requesters, with optional packet lock and start-acknowledge timeout.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_W    = DEFAULT_DATA_W,
    parameter int  START_TMO = 16,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      grant_valid,
    output logic                      err_tmo
);

    localparam int TMO_W = $clog2(START_TMO + 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               lock;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [TMO_W-1:0]   tmo_inc;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // A locked packet relaunches the held requester; otherwise the arbiter picks.
    assign sel_idx    = (state == RELEASE) ? grant_id : arb_idx;
    assign sel_onehot = (state == RELEASE) ? (NUM_REQ'(1) << grant_id) : arb_grant;
    assign sel_data   = req_data[sel_idx*DATA_W +: DATA_W];
    assign sel_last   = req_last[sel_idx];
    assign tmo_inc    = (tmo_cnt == TMO_W'(START_TMO)) ? tmo_cnt : tmo_cnt + 1'b1;
    assign ptr_next   = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lock        <= 1'b0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            err_tmo     <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            err_tmo   <= 1'b0;
            case (state)
                IDLE: begin
                    // Never launch over a frame still on the line (e.g. after reset).
                    if (!tx_busy && arb_any) begin
                        grant_id    <= arb_idx;
                        tx_start    <= 1'b1;
                        req_ready   <= sel_onehot;
                        tx_data     <= sel_data;
                        lock        <= ~sel_last;
                        tmo_cnt     <= '0;
                        grant_valid <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_cnt <= tmo_inc;
                    state   <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (tx_busy) begin
                        state <= WAIT_FALL;
                    end else if (tmo_cnt == TMO_W'(START_TMO - 1)) begin
                        err_tmo <= 1'b1;
                        lock    <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                WAIT_FALL: begin
                    if (!tx_busy) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (lock) begin
                        if (req_valid[grant_id]) begin
                            tx_start  <= 1'b1;
                            req_ready <= sel_onehot;
                            tx_data   <= sel_data;
                            lock      <= ~sel_last;
                            tmo_cnt   <= '0;
                            state     <= LOAD;
                        end
                    end else begin
                        rr_ptr      <= ptr_next;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration table plus lock, timeout,
// reset and stall sequences against a simple requester/transmitter model.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int START_TMO = 16;
    localparam int FRAME     = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy = 1'b0;
    logic [1:0]                grant_id;
    logic                      grant_valid;
    logic                      err_tmo;

    uart_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .START_TMO (START_TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .err_tmo     (err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] data;
        logic [3:0] rdy;
    } ent_t;

    typedef struct {
        logic [3:0] mask;
        int         n;
        int         order [4];
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] rq [NUM_REQ][$];
    ent_t       log_q [$];
    int         bus_cnt = 0;
    logic       bus_en = 1'b1;
    vec_t       vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*8 +: 8]    = rq[i][0][7:0];
                req_last[i]           = rq[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*8 +: 8]    = 8'h00;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
        refresh();
    endtask

    // One clock: requesters retire accepted bytes, transmitter model frames
    // FRAME busy cycles starting the cycle after tx_start, launches are logged.
    task automatic step();
        logic [3:0] rdy_prev;
        logic       st_prev;
        rdy_prev = req_ready;
        st_prev  = tx_start;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy_prev[i] === 1'b1 && rq[i].size() != 0) void'(rq[i].pop_front());
        end
        if (st_prev === 1'b1 && bus_en) bus_cnt = FRAME;
        else if (bus_cnt > 0) bus_cnt--;
        tx_busy = (bus_cnt != 0);
        refresh();
        if (tx_start === 1'b1) log_q.push_back('{grant_id, tx_data, req_ready});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (log_q.size() < n && c < budget) begin
            step();
            c++;
        end
        check(name, log_q.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((grant_valid !== 1'b0 || tx_busy) && c < 100) begin
            step();
            c++;
        end
        check(name, grant_valid, 0);
    endtask

    initial begin
        int n;
        int bad_start;
        int bad_gv;
        logic busy_prev;
        int exp_g [4];
        logic [7:0] exp_d [4];

        // Arbitration snapshots; rr_ptr carries over from one vector to the next.
        vecs[0] = '{4'b1111, 4, '{0, 1, 2, 3}};
        vecs[1] = '{4'b0001, 1, '{0, 0, 0, 0}};
        vecs[2] = '{4'b0101, 2, '{2, 0, 0, 0}};
        vecs[3] = '{4'b1001, 2, '{3, 0, 0, 0}};
        vecs[4] = '{4'b0010, 1, '{1, 0, 0, 0}};
        vecs[5] = '{4'b1010, 2, '{3, 1, 0, 0}};

        do_reset();
        check("rst_tx_start",    tx_start,    0);
        check("rst_req_ready",   req_ready,   0);
        check("rst_tx_data",     tx_data,     0);
        check("rst_grant_id",    grant_id,    0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_err_tmo",     err_tmo,     0);

        for (int v = 0; v < 6; v++) begin
            log_q.delete();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vecs[v].mask[i]) push(i, 8'(v*16 + i), 1'b1);
            end
            wait_starts(vecs[v].n, 300, $sformatf("tbl%0d_starts", v));
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k < log_q.size()) begin
                    check($sformatf("tbl%0d_gid%0d", v, k), log_q[k].gid, vecs[v].order[k]);
                    check($sformatf("tbl%0d_data%0d", v, k), log_q[k].data, 8'(v*16 + vecs[v].order[k]));
                    check($sformatf("tbl%0d_rdy%0d", v, k), log_q[k].rdy, 4'b0001 << vecs[v].order[k]);
                end
            end
            wait_idle($sformatf("tbl%0d_idle", v));
        end

        // Single request: launch one cycle after it is presented.
        do_reset();
        log_q.delete();
        push(2, 8'hA5, 1'b1);
        step();
        check("t1_tx_start",    tx_start,    1);
        check("t1_req_ready",   req_ready,   4'b0100);
        check("t1_tx_data",     tx_data,     8'hA5);
        check("t1_grant_id",    grant_id,    2);
        check("t1_grant_valid", grant_valid, 1);
        step();
        check("t1_start_pulse", tx_start,    0);
        check("t1_ready_pulse", req_ready,   0);
        check("t1_data_held",   tx_data,     8'hA5);
        wait_idle("t1_idle");
        check("t1_gid_held",    grant_id,    2);
        // rr_ptr is now 3: requester 3 beats requester 0.
        log_q.delete();
        push(0, 8'h60, 1'b1);
        push(3, 8'h63, 1'b1);
        wait_starts(2, 100, "t1_ptr_starts");
        if (log_q.size() == 2) begin
            check("t1_ptr_first",  log_q[0].gid, 3);
            check("t1_ptr_second", log_q[1].gid, 0);
        end
        wait_idle("t1_ptr_idle");

        // Packet lock: three bytes from requester 1 go out before requester 0.
        log_q.delete();
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b0);
        push(1, 8'hB3, 1'b1);
        push(0, 8'hC0, 1'b1);
        exp_g = '{1, 1, 1, 0};
        exp_d = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        wait_starts(4, 300, "t3_starts");
        for (int k = 0; k < 4; k++) begin
            if (k < log_q.size()) begin
                check($sformatf("t3_gid%0d", k),  log_q[k].gid,  exp_g[k]);
                check($sformatf("t3_data%0d", k), log_q[k].data, exp_d[k]);
            end
        end
        wait_idle("t3_idle");

        // Timeout: transmitter never acknowledges; lock from last=0 must clear.
        log_q.delete();
        bus_en = 1'b0;
        push(2, 8'h42, 1'b0);
        push(3, 8'h43, 1'b1);
        wait_starts(1, 50, "t4_first_start");
        n = 0;
        while (err_tmo !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("t4_tmo_latency", n, START_TMO);
        step();
        check("t4_tmo_pulse", err_tmo, 0);
        wait_starts(2, 50, "t4_next_start");
        if (log_q.size() == 2) begin
            check("t4_first_gid",  log_q[0].gid,  2);
            check("t4_first_data", log_q[0].data, 8'h42);
            check("t4_next_gid",   log_q[1].gid,  3);
        end
        n = 0;
        while (err_tmo !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("t4_second_tmo", err_tmo, 1);
        bus_en = 1'b1;
        wait_idle("t4_idle");

        // Reset in WAIT_FALL: outputs clear, relaunch waits for the frame to end.
        log_q.delete();
        push(3, 8'h53, 1'b1);
        wait_starts(1, 50, "t5_start");
        step();
        step();
        step();
        check("t5_busy_before_rst", tx_busy, 1);
        rst = 1'b1;
        step();
        check("t5_rst_tx_start",    tx_start,    0);
        check("t5_rst_req_ready",   req_ready,   0);
        check("t5_rst_tx_data",     tx_data,     0);
        check("t5_rst_grant_id",    grant_id,    0);
        check("t5_rst_grant_valid", grant_valid, 0);
        rst = 1'b0;
        log_q.delete();
        push(1, 8'h51, 1'b1);
        n = 0;
        bad_start = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            busy_prev = tx_busy;
            step();
            n++;
            if (tx_start === 1'b1 && busy_prev) bad_start++;
        end
        check("t5_start_over_busy", bad_start, 0);
        check("t5_relaunch_delay",  n, 8);
        check("t5_relaunch_gid",    grant_id, 1);
        wait_idle("t5_idle");

        // Locked requester stalls: grant held, requester 1 blocked until resume.
        log_q.delete();
        push(0, 8'hD0, 1'b0);
        push(1, 8'hE1, 1'b1);
        wait_starts(1, 50, "t6_first_start");
        if (log_q.size() == 1) begin
            check("t6_first_gid",  log_q[0].gid,  0);
            check("t6_first_data", log_q[0].data, 8'hD0);
        end
        bad_start = 0;
        bad_gv = 0;
        for (int c = 0; c < 35; c++) begin
            step();
            if (tx_start === 1'b1) bad_start++;
            if (grant_valid !== 1'b1) bad_gv++;
        end
        check("t6_stall_no_start",    bad_start, 0);
        check("t6_stall_grant_valid", bad_gv,    0);
        push(0, 8'hD1, 1'b1);
        wait_starts(3, 100, "t6_resume_starts");
        if (log_q.size() == 3) begin
            check("t6_resume_gid",  log_q[1].gid,  0);
            check("t6_resume_data", log_q[1].data, 8'hD1);
            check("t6_after_gid",   log_q[2].gid,  1);
            check("t6_after_data",  log_q[2].data, 8'hE1);
        end
        wait_idle("t6_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
